// File: rtl/fds_ss_engine_pkg.sv
// Shared types and constants for the FDS-sound save-state engine.
package fds_ss_engine_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TMR_W  = 4;

    localparam int unsigned DEF_FIRST_ADDR = 16;
    localparam int unsigned DEF_LAST_ADDR  = 123;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_PUSH,
        ST_PULL,
        ST_WRITE,
        ST_NEXT
    } state_e;

endpackage

// File: rtl/fds_ss_timer.sv
// Small load/decrement counter with a zero flag; paces address settling
// and write-strobe width.
//   clk, rst_n : clock, async active-low reset
//   load       : load count with load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   zero_c     : combinational, count == 0
module fds_ss_timer
    import fds_ss_engine_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [TMR_W-1:0] count;

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - TMR_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/fds_ss_engine.sv
// Save-state initiator for the FDS sound block. Walks slots FIRST_ADDR..
// LAST_ADDR and either dumps each slot to the tx stream (mode 0) or writes
// each rx stream byte into the slots (mode 1). Holds ss_act for the whole
// transfer so the sound block's register logic stays frozen.
//   start/mode/abort          : control from the host-side controller
//   busy/done                 : status (done is a one-clock pulse)
//   ss_act/ss_we/ss_addr/
//   ss_wdat/ss_rdat           : sound block save-state port
//   tx_dat/tx_valid/tx_ready  : save byte stream out
//   rx_dat/rx_valid/rx_ready  : load byte stream in (rx_ready follows state)
module fds_ss_engine
    import fds_ss_engine_pkg::*;
#(
    parameter int unsigned FIRST_ADDR = DEF_FIRST_ADDR,
    parameter int unsigned LAST_ADDR  = DEF_LAST_ADDR,
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned WE_HOLD    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ss_act,
    output logic              ss_we,
    output logic [ADDR_W-1:0] ss_addr,
    output logic [DATA_W-1:0] ss_wdat,
    input  logic [DATA_W-1:0] ss_rdat,
    output logic [DATA_W-1:0] tx_dat,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_dat,
    input  logic              rx_valid,
    output logic              rx_ready
);

    // Timer counts down to zero inclusive, so load one less than the hold length
    localparam logic [TMR_W-1:0]  SETTLE_LD = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0]  WE_LD     = TMR_W'(WE_HOLD - 1);
    localparam logic [ADDR_W-1:0] ADDR_LO   = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_HI   = ADDR_W'(LAST_ADDR);

    state_e            state, state_d;
    logic              mode_q, mode_d;
    logic              busy_d, done_d, ss_act_d, ss_we_d, tx_valid_d;
    logic [ADDR_W-1:0] ss_addr_d;
    logic [DATA_W-1:0] ss_wdat_d, tx_dat_d;
    logic              tmr_load_c, tmr_dec_c, tmr_zero_c;
    logic [TMR_W-1:0]  tmr_val_c;

    fds_ss_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .dec      (tmr_dec_c),
        .zero_c   (tmr_zero_c)
    );

    // Ready to accept a load byte exactly while waiting in PULL
    assign rx_ready = (state == ST_PULL);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ss_act   <= 1'b0;
            ss_we    <= 1'b0;
            ss_addr  <= ADDR_LO;
            ss_wdat  <= '0;
            tx_dat   <= '0;
            tx_valid <= 1'b0;
        end else begin
            state    <= state_d;
            mode_q   <= mode_d;
            busy     <= busy_d;
            done     <= done_d;
            ss_act   <= ss_act_d;
            ss_we    <= ss_we_d;
            ss_addr  <= ss_addr_d;
            ss_wdat  <= ss_wdat_d;
            tx_dat   <= tx_dat_d;
            tx_valid <= tx_valid_d;
        end
    end

    // Next-state and next-output logic; abort overrides everything
    always_comb begin
        state_d    = state;
        mode_d     = mode_q;
        busy_d     = busy;
        done_d     = 1'b0;
        ss_act_d   = ss_act;
        ss_we_d    = ss_we;
        ss_addr_d  = ss_addr;
        ss_wdat_d  = ss_wdat;
        tx_dat_d   = tx_dat;
        tx_valid_d = tx_valid;
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
        tmr_dec_c  = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            ss_act_d   = 1'b0;
            ss_we_d    = 1'b0;
            tx_valid_d = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_d    = mode;
                        ss_addr_d = ADDR_LO;
                        ss_act_d  = 1'b1;
                        busy_d    = 1'b1;
                        if (mode) begin
                            state_d = ST_PULL;
                        end else begin
                            state_d    = ST_SETTLE;
                            tmr_load_c = 1'b1;
                            tmr_val_c  = SETTLE_LD;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero_c) state_d = ST_SAMPLE;
                    else            tmr_dec_c = 1'b1;
                end
                ST_SAMPLE: begin
                    tx_dat_d   = ss_rdat;
                    tx_valid_d = 1'b1;
                    state_d    = ST_PUSH;
                end
                ST_PUSH: begin
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_NEXT;
                    end
                end
                ST_PULL: begin
                    if (rx_valid) begin
                        ss_wdat_d  = rx_dat;
                        ss_we_d    = 1'b1;
                        tmr_load_c = 1'b1;
                        tmr_val_c  = WE_LD;
                        state_d    = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // NEXT follows, keeping addr/data stable one clock past the strobe
                    if (tmr_zero_c) begin
                        ss_we_d = 1'b0;
                        state_d = ST_NEXT;
                    end else begin
                        tmr_dec_c = 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (ss_addr == ADDR_HI) begin
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        ss_act_d  = 1'b0;
                        ss_addr_d = ADDR_LO;
                        state_d   = ST_IDLE;
                    end else begin
                        ss_addr_d = ss_addr + ADDR_W'(1);
                        if (mode_q) begin
                            state_d = ST_PULL;
                        end else begin
                            state_d    = ST_SETTLE;
                            tmr_load_c = 1'b1;
                            tmr_val_c  = SETTLE_LD;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fds_ss_engine.sv
// Directed bench for fds_ss_engine: full save/load transfers from a vector
// table, plus abort, start-while-busy and async-reset sequences.
module tb_fds_ss_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, mode, abort;
    logic       busy, done, ss_act, ss_we;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, tx_dat, rx_dat;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Stub responder: each slot returns its address XOR 0x5A
    assign ss_rdat = ss_addr ^ 8'h5A;

    fds_ss_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .ss_act   (ss_act),
        .ss_we    (ss_we),
        .ss_addr  (ss_addr),
        .ss_wdat  (ss_wdat),
        .ss_rdat  (ss_rdat),
        .tx_dat   (tx_dat),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_dat   (rx_dat),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    typedef struct {
        bit         mode;
        int         stall;
        bit         gaps;
        int         poke;
        int         exp_bytes;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        int         exp_done;
        int         exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One complete transfer; per-cycle checks on stream order, stall stability and strobe width
    task automatic run_xfer(input vec_t v, output int bytes, output logic [7:0] first,
                            output logic [7:0] last, output int dones, output int lat);
        int         cyc, sent, we_len, post;
        bit         prev_stall, prev_we, fin;
        logic [7:0] prev_dat;
        bytes = 0; first = '0; last = '0; dones = 0; lat = -1;
        cyc = 0; sent = 0; we_len = 0; post = 0;
        prev_stall = 0; prev_we = 0; fin = 0; prev_dat = '0;
        start = 1'b1; mode = v.mode; tx_ready = 1'b1; rx_valid = 1'b0; rx_dat = '0;
        while (!fin) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == v.poke) begin start = 1'b1; mode = !v.mode; end
            else begin start = 1'b0; mode = v.mode; end
            if (lat < 0 && (v.mode ? rx_ready : tx_valid)) lat = cyc;
            if (!v.mode) begin
                chk("save_no_we", 32'(ss_we), 32'd0);
                if (prev_stall) begin
                    chk("stall_valid", 32'(tx_valid), 32'd1);
                    chk("stall_dat", 32'(tx_dat), 32'(prev_dat));
                end
                tx_ready = (v.stall == 0) ? 1'b1 : (((cyc / v.stall) % 2) == 0);
                if (tx_valid && tx_ready) begin
                    chk("tx_dat", 32'(tx_dat), 32'(8'(16 + bytes) ^ 8'h5A));
                    if (bytes == 0) first = tx_dat;
                    last = tx_dat;
                    bytes++;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_dat   = tx_dat;
            end else begin
                if (ss_we) begin
                    we_len++;
                    chk("we_addr", 32'(ss_addr), 32'(8'(16 + bytes)));
                    chk("we_wdat", 32'(ss_wdat), 32'(8'(bytes)));
                end else if (prev_we) begin
                    chk("we_len", 32'(we_len), 32'd4);
                    chk("we_addr_hold", 32'(ss_addr), 32'(8'(16 + bytes)));
                    if (bytes == 0) first = ss_wdat;
                    last = ss_wdat;
                    bytes++;
                    we_len = 0;
                end
                prev_we  = ss_we;
                rx_valid = (sent < 108) && (!v.gaps || ($urandom_range(0, 2) != 0));
                rx_dat   = 8'(sent);
                if (rx_valid && rx_ready) sent++;
            end
            if (done) begin
                dones++;
                chk("done_act", 32'(ss_act), 32'd0);
                chk("done_busy", 32'(busy), 32'd0);
            end
            if (dones > 0) post++;
            if (post >= 3) fin = 1;
            if (cyc >= 6000) begin
                n_checks++; n_errors++;
                $display("FAIL xfer_timeout: actual %0d bytes required %0d", bytes, v.exp_bytes);
                fin = 1;
            end
        end
        start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    initial begin
        vec_t       vecs [5];
        int         bytes, dones, lat, rises, sent, ndone;
        logic [7:0] first, last;
        bit         found, prev_we;

        vecs[0] = '{0, 0, 0,   0, 108, 8'h4A, 8'h21, 1, 4};
        vecs[1] = '{0, 3, 0,   0, 108, 8'h4A, 8'h21, 1, 4};
        vecs[2] = '{0, 2, 0, 100, 108, 8'h4A, 8'h21, 1, 4};
        vecs[3] = '{1, 0, 1,   0, 108, 8'h00, 8'h6B, 1, 1};
        vecs[4] = '{1, 0, 0, 200, 108, 8'h00, 8'h6B, 1, 1};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_act", 32'(ss_act), 32'd0);
        chk("rst_addr", 32'(ss_addr), 32'h10);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(ss_we), 32'd0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_rxr", 32'(rx_ready), 32'd0);
        chk("rst_wdat", 32'(ss_wdat), 32'd0);
        chk("rst_txdat", 32'(tx_dat), 32'd0);

        // Table-driven full transfers
        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i], bytes, first, last, dones, lat);
            chk($sformatf("v%0d_bytes", i), 32'(bytes), 32'(vecs[i].exp_bytes));
            chk($sformatf("v%0d_first", i), 32'(first), 32'(vecs[i].exp_first));
            chk($sformatf("v%0d_last", i), 32'(last), 32'(vecs[i].exp_last));
            chk($sformatf("v%0d_done", i), 32'(dones), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_addr", i), 32'(ss_addr), 32'h10);
        end

        // Abort mid-WRITE of the 50th load byte, with start coincident
        rises = 0; sent = 0; found = 0; prev_we = 0; ndone = 0;
        start = 1'b1; mode = 1'b1; rx_valid = 1'b1; rx_dat = '0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) ndone++;
            if (ss_we && !prev_we) rises++;
            prev_we = ss_we;
            rx_dat = 8'(sent);
            if (rx_ready) sent++;
            if (rises == 50) found = 1;
        end
        chk("abort_reach", 32'(found), 32'd1);
        @(posedge clk); #1;
        chk("abort_pre_we", 32'(ss_we), 32'd1);
        chk("abort_pre_addr", 32'(ss_addr), 32'(8'd65));
        abort = 1'b1; start = 1'b1; rx_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abort_we", 32'(ss_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_act", 32'(ss_act), 32'd0);
        chk("abort_rxr", 32'(rx_ready), 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_stay_idle", 32'(busy), 32'd0);
        start = 1'b1; mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_addr", 32'(ss_addr), 32'h10);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_rxr", 32'(rx_ready), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort2_busy", 32'(busy), 32'd0);

        // start together with abort while idle is ignored
        abort = 1'b1; start = 1'b1; mode = 1'b0; tx_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("coinc_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("coinc_txv", 32'(tx_valid), 32'd0);
        chk("coinc_act", 32'(ss_act), 32'd0);

        // Async reset while stalled in PUSH
        tx_ready = 1'b0; start = 1'b1; mode = 1'b0; found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (tx_valid) found = 1;
        end
        chk("push_reach", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_txv", 32'(tx_valid), 32'd0);
        chk("arst_act", 32'(ss_act), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle_busy", 32'(busy), 32'd0);
        chk("arst_idle_addr", 32'(ss_addr), 32'h10);
        chk("arst_idle_rxr", 32'(rx_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("arst_idle_txv", 32'(tx_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
